if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage for the five-stage MIPS pipeline, sitting upstream of the decode stage. It owns the PC and drives a one-outstanding request/acknowledge instruction-SRAM port. It produces the `{ce, pc}` IF→ID bus plus a held instruction word, and consumes the decode stage's branch bus `{br_e, br_addr}` with one architectural delay slot. It raises a stall request whenever decode is ready to advance but no fetched instruction is available.

## Interface
- `RESET_PC`, default 32'hBFC0_0000, first fetch address after reset.

- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous, active-low reset.
- `stall` in `StallBus` — pipeline stall vector; only `stall[1]` (IF/ID) and `stall[2]` (ID/EX) are used.
- `br_bus` in `BR_WD` — `{br_e, br_addr[31:0]}` from decode; combinational, valid while decode holds the branch.
- `if_to_id_bus` out `IF_TO_ID_WD` — `{ce, pc[31:0]}`. `ce`=1 marks a valid instruction.
- `fetch_inst` out 32 — instruction word for `pc`; stable while `ce`=1.
- `stallreq_if` out 1 — 1 when no valid instruction is presented.
- `inst_req` out 1 — fetch request.
- `inst_addr` out 32 — word-aligned fetch address.
- `inst_addr_ok` in 1 — request accepted this cycle.
- `inst_data_ok` in 1 — read data valid this cycle.
- `inst_rdata` in 32 — read data.

## Operation
- FSM states:
  - IDLE (reset state)
  - REQ (`inst_req`=1, waiting for `addr_ok`)
  - WAIT (accepted, waiting for `data_ok`)
  - HOLD (instruction buffered, `ce`=1)
- Transitions:
  - IDLE→REQ: unconditionally, on the first edge after `rst` deasserts.
  - REQ→WAIT: on `inst_addr_ok`.
  - WAIT→HOLD: on `inst_data_ok`; `inst_rdata` is captured into `fetch_inst`.
  - HOLD with `stall[1]`=NoStop (consume):
    - `inst_req`=1 combinationally, with `inst_addr`=next PC.
    - Goes to WAIT if `inst_addr_ok`, else REQ.
    - `pc` advances to next PC.
  - HOLD with `stall[1]`=Stop: stays in HOLD, `fetch_inst` and `pc` are unchanged.
- Next PC: `redir_v ? redir_addr : pc+4`, with 32-bit wrap. `redir_v` clears when consumed.
- Redirect capture:
  - On any edge with `br_e`=1 and `stall[2]`=NoStop (the branch leaves decode), set `redir_v`=1 and `redir_addr`=`br_addr`.
  - The instruction currently being fetched or held is the delay slot; the redirect applies to the fetch after it.
- Simultaneous capture and consume: HOLD consume on the same edge as a capture uses `br_addr` directly as next PC, and `redir_v` stays 0.
- `br_e` while `stall[2]`=Stop is ignored; decode re-presents the branch until it leaves.
- `inst_addr_ok` outside REQ/HOLD-consume and `inst_data_ok` outside WAIT are ignored; this covers a stale response after a mid-transaction reset.
- `stallreq_if` = (state≠HOLD).

## Timing
- Reset values:
  - state IDLE
  - `pc`=`RESET_PC`
  - `ce`=0
  - `fetch_inst`=0
  - `inst_req`=0
  - `inst_addr`=`RESET_PC`
  - `redir_v`=0, `redir_addr`=0
  - `stallreq_if`=1
- `inst_req` and `inst_addr` are driven from state and registers plus the HOLD-consume term. They are held constant in REQ until `addr_ok`.
- SRAM handshake: at most one request outstanding. `data_ok` arrives no earlier than the cycle after `addr_ok`.
- Latency, `addr_ok`-to-`ce`: 1 cycle after `data_ok`.
- Best-case throughput: one instruction per 2 cycles with a 1-cycle SRAM.
- Reset assertion mid-operation clears all state immediately (asynchronous); no request is reissued until IDLE→REQ.

## Structure
- Shared `lib/defines.vh` supplies:
  - `StallBus`, `Stop`, `NoStop`
  - `BR_WD`(33)
  - `IF_TO_ID_WD`(33)
- FSM state encodings are `localparam`s inside the module.
- No sub-module is warranted: the PC mux, redirect register and FSM form a single block.

## Test plan
- Reset release, SRAM with `addr_ok` immediate and `data_ok` +1: first `inst_req` at 0xBFC0_0000 one cycle after release; `ce`=1, `pc`=0xBFC0_0000 two cycles later; next request 0xBFC0_0004.
- Branch at 0xBFC0_0008 with `br_addr`=0xBFC0_0100, leaving decode while the delay slot 0xBFC0_000C is in WAIT: the delay slot is delivered, then the fetch goes to 0xBFC0_0100 (not 0xBFC0_0010).
- Branch leaving decode on the same edge the delay slot is consumed from HOLD: the very next `inst_addr` is 0xBFC0_0100.
- `stall[1]`=Stop for 5 cycles in HOLD: `ce`=1, `pc`, `fetch_inst` constant, `inst_req`=0, `stallreq_if`=0 throughout.
- `addr_ok` withheld 3 cycles: `inst_req`/`inst_addr` stable, `stallreq_if`=1 each cycle.
- `rst` asserted in WAIT, then a stray `data_ok` after release: outputs return to reset values immediately, the stray `data_ok` is ignored, and fetch restarts at 0xBFC0_0000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared bus widths, stall encodings and PC helpers for if_fetch
package if_fetch_pkg;

    localparam int STALL_WD    = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    // Per-stage stall encoding: Stop freezes the stage register, NoStop lets it advance
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef logic [STALL_WD-1:0] stall_bus_t;

    // Sequential successor of a fetch address; wraps naturally at 32 bits
    function automatic logic [31:0] pc_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Fetch addresses are always word aligned, whatever decode hands us
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, redirect register and SRAM request FSM
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  stall_bus_t             stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            fetch_inst,
    output logic                   stallreq_if,
    output logic                   inst_req,
    output logic [31:0]            inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [31:0]            inst_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redir_v;
    logic [31:0] redir_addr;
    logic        br_e;
    logic [31:0] br_addr;
    logic        capture;
    logic        consume;
    logic        unused_stall;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // Only the IF/ID and ID/EX stall bits matter to this stage
    assign unused_stall = ^{stall[STALL_WD-1:3], stall[0]};

    // The branch leaves decode on this edge; its delay slot is whatever we are fetching now
    assign capture = br_e && (stall[2] == NoStop);
    // Decode takes the buffered instruction on this edge
    assign consume = (state == S_HOLD) && (stall[1] == NoStop);

    // A branch leaving on the consume edge bypasses the redirect register entirely
    assign next_pc = word_align(capture ? br_addr : (redir_v ? redir_addr : pc_seq(pc)));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stray handshakes outside their state are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  if (inst_addr_ok) state_nxt = S_WAIT;
            S_WAIT: if (inst_data_ok) state_nxt = S_HOLD;
            S_HOLD: if (consume) state_nxt = inst_addr_ok ? S_WAIT : S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request outputs: REQ repeats pc, a HOLD consume issues the next PC in the same cycle
    always_comb begin
        inst_req  = (state == S_REQ) || consume;
        inst_addr = consume ? next_pc : pc;
    end

    // PC, instruction buffer and pending-redirect register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            fetch_inst <= 32'h0;
            redir_v    <= 1'b0;
            redir_addr <= 32'h0;
        end else begin
            if ((state == S_WAIT) && inst_data_ok) begin
                fetch_inst <= inst_rdata;
            end
            if (consume) begin
                pc      <= next_pc;
                redir_v <= 1'b0;
            end else if (capture) begin
                redir_v    <= 1'b1;
                redir_addr <= br_addr;
            end
        end
    end

    assign if_to_id_bus = {(state == S_HOLD), pc};
    assign stallreq_if  = (state != S_HOLD);

endmodule
